ltc2324_acq_ctrl: RTL

Acquisition sequencer between the software/DMA control plane and the LTC2324_16 driver. Gates the driver's `sample_en`, decimates its free-running 4-channel results, and captures a programmed number of samples. Serialises the enabled channels onto a 16-bit AXI-Stream master feeding the DMA, with `tlast` on the final beat. Reports busy, done and overflow status.

---
 rtl/ltc2324_acq_ctrl_if.sv | 17 +
 rtl/ltc2324_acq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ltc2324_acq_ctrl_if.sv
`default_nettype none
// ============================================================================
// ltc2324_acq_ctrl_if : AXI-Stream beat bus from the acquisition sequencer.
// Rev 1.0
// ============================================================================
interface ltc2324_acq_ctrl_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/ltc2324_acq_ctrl.sv
`default_nettype none
// ============================================================================
// ltc2324_acq_ctrl : gates the LTC2324 driver, decimates its 4-channel results
// and serialises a programmed number of samples onto an AXI-Stream master.
// Rev 1.0
// ============================================================================
module ltc2324_acq_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [CNT_W-1:0]    cfg_count_i,
  input  logic [15:0]         cfg_decim_i,
  input  logic [3:0]          cfg_ch_mask_i,
  output logic                adc_sample_en_o,
  input  logic                adc_valid_i,
  input  logic [DATA_W-1:0]   adc_ch1_i,
  input  logic [DATA_W-1:0]   adc_ch2_i,
  input  logic [DATA_W-1:0]   adc_ch3_i,
  input  logic [DATA_W-1:0]   adc_ch4_i,
  ltc2324_acq_ctrl_if.master  m_axis,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o,
  output logic                overflow_o,
  output logic [CNT_W-1:0]    samples_done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                   state_q,     state_d;
  logic [CNT_W-1:0]         count_q,     count_d;
  logic [15:0]              decim_q,     decim_d;
  logic [3:0]               mask_q,      mask_d;
  logic [15:0]              dec_cnt_q,   dec_cnt_d;
  logic [CNT_W-1:0]         samples_q,   samples_d;
  logic [3:0][DATA_W-1:0]   buf_q,       buf_d;
  logic [3:0]               pend_q,      pend_d;
  logic                     last_q,      last_d;
  logic                     sample_en_q, sample_en_d;
  logic                     done_q,      done_d;
  logic                     aborted_q,   aborted_d;
  logic                     overflow_q,  overflow_d;

  logic                     tvalid;
  logic                     hs;
  logic [3:0]               pend_rest;
  logic                     single_pend;
  logic                     last_hs;
  logic                     buf_free;
  logic                     keep;
  logic [CNT_W-1:0]         samples_inc;
  logic [1:0]               beat_idx;

  // Lowest pending channel is the one currently on the bus.
  always_comb begin
    beat_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) beat_idx = 2'(i);
    end
  end

  assign tvalid      = |pend_q;
  assign hs          = tvalid && m_axis.tready;
  assign pend_rest   = pend_q & (pend_q - 4'd1);
  assign single_pend = tvalid && (pend_rest == 4'd0);
  assign last_hs     = hs && single_pend;
  assign buf_free    = !tvalid || last_hs;
  assign keep        = adc_valid_i && (dec_cnt_q == 16'd0);
  assign samples_inc = samples_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    decim_d     = decim_q;
    mask_d      = mask_q;
    dec_cnt_d   = dec_cnt_q;
    samples_d   = samples_q;
    buf_d       = buf_q;
    pend_d      = hs ? pend_rest : pend_q;
    last_d      = last_q;
    sample_en_d = sample_en_q;
    done_d      = 1'b0;
    aborted_d   = aborted_q;
    overflow_d  = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && (cfg_count_i != '0) && (cfg_ch_mask_i != 4'd0)) begin
          count_d     = cfg_count_i;
          decim_d     = cfg_decim_i;
          mask_d      = cfg_ch_mask_i;
          dec_cnt_d   = 16'd0;
          samples_d   = '0;
          overflow_d  = 1'b0;
          aborted_d   = 1'b0;
          last_d      = 1'b0;
          sample_en_d = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (adc_valid_i) begin
          dec_cnt_d = (dec_cnt_q == decim_q) ? 16'd0 : dec_cnt_q + 16'd1;
        end
        if (keep) begin
          if (buf_free) begin
            buf_d     = {adc_ch4_i, adc_ch3_i, adc_ch2_i, adc_ch1_i};
            pend_d    = mask_q;
            samples_d = samples_inc;
            last_d    = (samples_inc == count_q);
            if (samples_inc == count_q) begin
              sample_en_d = 1'b0;
              state_d     = ST_FLUSH;
            end
          end else begin
            overflow_d = 1'b1;
          end
        end
        // Whatever remains buffered (including a same-cycle capture) closes the stream.
        if (stop_i) begin
          sample_en_d = 1'b0;
          aborted_d   = 1'b1;
          last_d      = 1'b1;
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (pend_d == 4'd0) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      decim_q     <= 16'd0;
      mask_q      <= 4'd0;
      dec_cnt_q   <= 16'd0;
      samples_q   <= '0;
      buf_q       <= '0;
      pend_q      <= 4'd0;
      last_q      <= 1'b0;
      sample_en_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      decim_q     <= decim_d;
      mask_q      <= mask_d;
      dec_cnt_q   <= dec_cnt_d;
      samples_q   <= samples_d;
      buf_q       <= buf_d;
      pend_q      <= pend_d;
      last_q      <= last_d;
      sample_en_q <= sample_en_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      overflow_q  <= overflow_d;
    end
  end

  assign m_axis.tdata    = buf_q[beat_idx];
  assign m_axis.tvalid   = tvalid;
  assign m_axis.tlast    = last_q && single_pend;
  assign adc_sample_en_o = sample_en_q;
  assign busy_o          = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done_o          = done_q;
  assign aborted_o       = aborted_q;
  assign overflow_o      = overflow_q;
  assign samples_done_o  = samples_q;

endmodule
`default_nettype wire
